y86_pipe_regs: RTL and testbench
================================

Name: y86_pipe_regs

Overview:
- Pipeline-register bank for the Y86-64 pipeline: the F (predicted PC), D (fetch→decode) and E (decode→execute) registers.
- Consumes the hazard controller's F_stall, D_stall, D_bubble and E_bubble and applies them at the clock edge: hold, load, or insert a NOP bubble.
- Also keeps saturating stall/bubble event counters and a sticky flag for illegal control combinations, for debug and verification.

Parameters:
- DATA_W, 64, width of PC and all val* fields
- RESET_PC, 0, F_predPC value after reset
- CNT_W, 16, width of each event counter

Ports:
- clk  in  1  single clock; all registers update on rising edge
- reset_n  in  1  asynchronous, active-low reset
- F_stall  in  1  hold F register
- D_stall  in  1  hold D register
- D_bubble  in  1  load NOP bubble into D
- E_bubble  in  1  load NOP bubble into E
- f_predPC  in  DATA_W  next predicted PC from fetch
- f_stat, f_icode, f_ifun, f_rA, f_rB  in  4 each  fetch outputs
- f_valC, f_valP  in  DATA_W each  fetch outputs
- d_stat, d_icode, d_ifun  in  4 each  decode outputs
- d_valC, d_valA, d_valB  in  DATA_W each  decode outputs
- d_dstE, d_dstM, d_srcA, d_srcB  in  4 each  decode register IDs
- F_predPC  out  DATA_W  F register
- D_stat, D_icode, D_ifun, D_rA, D_rB  out  4 each  D register
- D_valC, D_valP  out  DATA_W each  D register
- E_stat, E_icode, E_ifun, E_dstE, E_dstM, E_srcA, E_srcB  out  4 each  E register
- E_valC, E_valA, E_valB  out  DATA_W each  E register
- stall_cnt  out  CNT_W  count of cycles with F_stall or D_stall high
- bubble_cnt  out  CNT_W  count of cycles with D_bubble or E_bubble high
- ctrl_err  out  1  sticky: D_stall and D_bubble were high in the same cycle

Behaviour:
Bubble encoding:
- icode=4'h1 (NOP), ifun=0, stat=4'h1 (SAOK).
- rA, rB, dstE, dstM, srcA, srcB = 4'hF (RNONE).
- valC, valP, valA, valB = 0.

Reset (reset_n low, asynchronous, takes effect immediately regardless of clk):
- F_predPC=RESET_PC.
- D and E registers hold the bubble encoding.
- stall_cnt=0, bubble_cnt=0, ctrl_err=0.
- Release is synchronous to the next rising edge. Reset asserted mid-stall discards the held state.

F register, each edge:
- F_stall=1: hold.
- Otherwise: load f_predPC.

D register, priority order:
1. D_stall=1: hold. Stall wins over bubble; ctrl_err is set when D_bubble is also high.
2. Else D_bubble=1: load the bubble encoding.
3. Else: load the f_* fields.

E register:
- E_bubble=1: load the bubble encoding.
- Otherwise: load the d_* fields. The E register has no stall input.

General timing:
- All outputs are registered; load latency is 1 cycle.
- Held values remain stable for any number of consecutive stall cycles.

Counters:
- Each counter increments by 1 per qualifying cycle.
- Counters saturate at all-ones and never wrap.
- A cycle with both F_stall and D_stall high counts once in stall_cnt.
- A cycle with both D_bubble and E_bubble high counts once in bubble_cnt.
- Counters and ctrl_err clear only on reset.

Combinations produced by the controller, each handled by the rules above:
- Load/use hazard: F_stall, D_stall and E_bubble together → F and D hold, E becomes a bubble.
- Mispredicted branch: D_bubble and E_bubble together → both become bubbles, F loads.
- ret in flight: F_stall and D_bubble together → F holds, D becomes a bubble, E loads.

Test Plan:
- Reset: assert reset_n=0 between clock edges → outputs change at once to F_predPC=RESET_PC, D_icode=E_icode=4'h1, D_rA=E_dstE=4'hF, counters 0. Release, drive f_predPC=0x10 → F_predPC=0x10 after 1 edge.
- Normal flow: f_icode=4'h3, f_rB=4'h2, f_valC=0x1234, then d_icode=4'h3, d_dstE=4'h2, all controls 0 → D_icode=4'h3 and D_valC=0x1234 one edge later. Next edge with d_* applied → E_icode=4'h3, E_dstE=4'h2.
- Load/use: hold F_stall=D_stall=E_bubble=1 for 2 cycles while f_* changes → F_predPC and D_* unchanged for 2 cycles, E_icode=4'h1 and E_dstM=4'hF, stall_cnt=2, bubble_cnt=2.
- Mispredict: D_bubble=E_bubble=1 for 1 cycle → D_icode=E_icode=4'h1 and D_valP=E_valA=0, F_predPC loads f_predPC, bubble_cnt increments by 1.
- Conflict: D_stall=D_bubble=1 → D held, not bubbled, and ctrl_err=1. ctrl_err stays 1 after both controls drop, until reset.
- Saturation, with CNT_W=4: hold F_stall=1 for 20 cycles → stall_cnt stops at 15 and never wraps to 0. Then pulse reset_n low mid-stall → stall_cnt=0 and F_predPC=RESET_PC.

Source files
------------

// File: rtl/y86_pipe_regs.sv
// Y86-64 pipeline register bank: F (predicted PC), D (fetch->decode) and
// E (decode->execute) registers, plus debug counters and a sticky flag for
// the illegal D_stall+D_bubble combination.
module y86_pipe_regs #(
    parameter int              DATA_W   = 64,
    parameter logic [DATA_W-1:0] RESET_PC = '0,
    parameter int              CNT_W    = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              F_stall,
    input  logic              D_stall,
    input  logic              D_bubble,
    input  logic              E_bubble,
    input  logic [DATA_W-1:0] f_predPC,
    input  logic [3:0]        f_stat,
    input  logic [3:0]        f_icode,
    input  logic [3:0]        f_ifun,
    input  logic [3:0]        f_rA,
    input  logic [3:0]        f_rB,
    input  logic [DATA_W-1:0] f_valC,
    input  logic [DATA_W-1:0] f_valP,
    input  logic [3:0]        d_stat,
    input  logic [3:0]        d_icode,
    input  logic [3:0]        d_ifun,
    input  logic [DATA_W-1:0] d_valC,
    input  logic [DATA_W-1:0] d_valA,
    input  logic [DATA_W-1:0] d_valB,
    input  logic [3:0]        d_dstE,
    input  logic [3:0]        d_dstM,
    input  logic [3:0]        d_srcA,
    input  logic [3:0]        d_srcB,
    output logic [DATA_W-1:0] F_predPC,
    output logic [3:0]        D_stat,
    output logic [3:0]        D_icode,
    output logic [3:0]        D_ifun,
    output logic [3:0]        D_rA,
    output logic [3:0]        D_rB,
    output logic [DATA_W-1:0] D_valC,
    output logic [DATA_W-1:0] D_valP,
    output logic [3:0]        E_stat,
    output logic [3:0]        E_icode,
    output logic [3:0]        E_ifun,
    output logic [3:0]        E_dstE,
    output logic [3:0]        E_dstM,
    output logic [3:0]        E_srcA,
    output logic [3:0]        E_srcB,
    output logic [DATA_W-1:0] E_valC,
    output logic [DATA_W-1:0] E_valA,
    output logic [DATA_W-1:0] E_valB,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt,
    output logic              ctrl_err
);

    localparam logic [3:0] I_NOP = 4'h1;
    localparam logic [3:0] S_AOK = 4'h1;
    localparam logic [3:0] R_NONE = 4'hF;

    logic [DATA_W-1:0] r_F_predPC;

    logic [3:0]        r_D_stat, r_D_icode, r_D_ifun, r_D_rA, r_D_rB;
    logic [DATA_W-1:0] r_D_valC, r_D_valP;

    logic [3:0]        r_E_stat, r_E_icode, r_E_ifun;
    logic [3:0]        r_E_dstE, r_E_dstM, r_E_srcA, r_E_srcB;
    logic [DATA_W-1:0] r_E_valC, r_E_valA, r_E_valB;

    logic [CNT_W-1:0]  r_stall_cnt, r_bubble_cnt;
    logic              r_ctrl_err;

    logic w_stall_ev, w_bubble_ev, w_conflict;

    assign w_stall_ev  = F_stall | D_stall;
    assign w_bubble_ev = D_bubble | E_bubble;
    assign w_conflict  = D_stall & D_bubble;

    // F register: hold on stall, otherwise take the next predicted PC
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_F_predPC <= RESET_PC;
        end else if (!F_stall) begin
            r_F_predPC <= f_predPC;
        end
    end

    // D register: stall beats bubble, bubble beats normal load
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_D_stat  <= S_AOK;
            r_D_icode <= I_NOP;
            r_D_ifun  <= 4'h0;
            r_D_rA    <= R_NONE;
            r_D_rB    <= R_NONE;
            r_D_valC  <= '0;
            r_D_valP  <= '0;
        end else if (D_stall) begin
            r_D_stat  <= r_D_stat;
            r_D_icode <= r_D_icode;
            r_D_ifun  <= r_D_ifun;
            r_D_rA    <= r_D_rA;
            r_D_rB    <= r_D_rB;
            r_D_valC  <= r_D_valC;
            r_D_valP  <= r_D_valP;
        end else if (D_bubble) begin
            r_D_stat  <= S_AOK;
            r_D_icode <= I_NOP;
            r_D_ifun  <= 4'h0;
            r_D_rA    <= R_NONE;
            r_D_rB    <= R_NONE;
            r_D_valC  <= '0;
            r_D_valP  <= '0;
        end else begin
            r_D_stat  <= f_stat;
            r_D_icode <= f_icode;
            r_D_ifun  <= f_ifun;
            r_D_rA    <= f_rA;
            r_D_rB    <= f_rB;
            r_D_valC  <= f_valC;
            r_D_valP  <= f_valP;
        end
    end

    // E register: no stall path, bubble or load every edge
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_E_stat  <= S_AOK;
            r_E_icode <= I_NOP;
            r_E_ifun  <= 4'h0;
            r_E_dstE  <= R_NONE;
            r_E_dstM  <= R_NONE;
            r_E_srcA  <= R_NONE;
            r_E_srcB  <= R_NONE;
            r_E_valC  <= '0;
            r_E_valA  <= '0;
            r_E_valB  <= '0;
        end else if (E_bubble) begin
            r_E_stat  <= S_AOK;
            r_E_icode <= I_NOP;
            r_E_ifun  <= 4'h0;
            r_E_dstE  <= R_NONE;
            r_E_dstM  <= R_NONE;
            r_E_srcA  <= R_NONE;
            r_E_srcB  <= R_NONE;
            r_E_valC  <= '0;
            r_E_valA  <= '0;
            r_E_valB  <= '0;
        end else begin
            r_E_stat  <= d_stat;
            r_E_icode <= d_icode;
            r_E_ifun  <= d_ifun;
            r_E_dstE  <= d_dstE;
            r_E_dstM  <= d_dstM;
            r_E_srcA  <= d_srcA;
            r_E_srcB  <= d_srcB;
            r_E_valC  <= d_valC;
            r_E_valA  <= d_valA;
            r_E_valB  <= d_valB;
        end
    end

    // Saturating event counters; simultaneous controls count as one event
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_stall_cnt  <= '0;
            r_bubble_cnt <= '0;
        end else begin
            if (w_stall_ev && (r_stall_cnt != {CNT_W{1'b1}})) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
            if (w_bubble_ev && (r_bubble_cnt != {CNT_W{1'b1}})) begin
                r_bubble_cnt <= r_bubble_cnt + 1'b1;
            end
        end
    end

    // Sticky flag for the stall+bubble conflict on D; only reset clears it
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ctrl_err <= 1'b0;
        end else if (w_conflict) begin
            r_ctrl_err <= 1'b1;
        end
    end

    assign F_predPC   = r_F_predPC;
    assign D_stat     = r_D_stat;
    assign D_icode    = r_D_icode;
    assign D_ifun     = r_D_ifun;
    assign D_rA       = r_D_rA;
    assign D_rB       = r_D_rB;
    assign D_valC     = r_D_valC;
    assign D_valP     = r_D_valP;
    assign E_stat     = r_E_stat;
    assign E_icode    = r_E_icode;
    assign E_ifun     = r_E_ifun;
    assign E_dstE     = r_E_dstE;
    assign E_dstM     = r_E_dstM;
    assign E_srcA     = r_E_srcA;
    assign E_srcB     = r_E_srcB;
    assign E_valC     = r_E_valC;
    assign E_valA     = r_E_valA;
    assign E_valB     = r_E_valB;
    assign stall_cnt  = r_stall_cnt;
    assign bubble_cnt = r_bubble_cnt;
    assign ctrl_err   = r_ctrl_err;

endmodule

// File: tb/tb_y86_pipe_regs.sv
// Testbench for y86_pipe_regs: directed scenarios plus randomized control and
// data, compared every cycle against a record-level reference model.
module tb_y86_pipe_regs;

    localparam int          DATA_W   = 64;
    localparam logic [63:0] RESET_PC = 64'h0000_0000_0000_0100;
    localparam int          CNT_W    = 4;
    localparam int          CNT_MAX  = (1 << CNT_W) - 1;

    typedef struct packed {
        logic [3:0]  stat, icode, ifun, rA, rB;
        logic [63:0] valC, valP;
    } d_rec_t;

    typedef struct packed {
        logic [3:0]  stat, icode, ifun, dstE, dstM, srcA, srcB;
        logic [63:0] valC, valA, valB;
    } e_rec_t;

    localparam d_rec_t D_NOP = '{stat: 4'h1, icode: 4'h1, ifun: 4'h0, rA: 4'hF, rB: 4'hF,
                                 valC: 64'h0, valP: 64'h0};
    localparam e_rec_t E_NOP = '{stat: 4'h1, icode: 4'h1, ifun: 4'h0, dstE: 4'hF, dstM: 4'hF,
                                 srcA: 4'hF, srcB: 4'hF, valC: 64'h0, valA: 64'h0, valB: 64'h0};

    logic clk = 1'b0;
    logic reset_n;
    logic F_stall, D_stall, D_bubble, E_bubble;
    logic [63:0] f_predPC, f_valC, f_valP, d_valC, d_valA, d_valB;
    logic [3:0]  f_stat, f_icode, f_ifun, f_rA, f_rB;
    logic [3:0]  d_stat, d_icode, d_ifun, d_dstE, d_dstM, d_srcA, d_srcB;
    logic [63:0] F_predPC, D_valC, D_valP, E_valC, E_valA, E_valB;
    logic [3:0]  D_stat, D_icode, D_ifun, D_rA, D_rB;
    logic [3:0]  E_stat, E_icode, E_ifun, E_dstE, E_dstM, E_srcA, E_srcB;
    logic [CNT_W-1:0] stall_cnt, bubble_cnt;
    logic ctrl_err;

    int checks = 0;
    int errors = 0;

    logic [63:0] m_F;
    d_rec_t      m_D;
    e_rec_t      m_E;
    int          m_stall, m_bubble;
    logic        m_err;

    always #5 clk = ~clk;

    y86_pipe_regs #(.DATA_W(DATA_W), .RESET_PC(RESET_PC), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset_n(reset_n),
        .F_stall(F_stall), .D_stall(D_stall), .D_bubble(D_bubble), .E_bubble(E_bubble),
        .f_predPC(f_predPC), .f_stat(f_stat), .f_icode(f_icode), .f_ifun(f_ifun),
        .f_rA(f_rA), .f_rB(f_rB), .f_valC(f_valC), .f_valP(f_valP),
        .d_stat(d_stat), .d_icode(d_icode), .d_ifun(d_ifun),
        .d_valC(d_valC), .d_valA(d_valA), .d_valB(d_valB),
        .d_dstE(d_dstE), .d_dstM(d_dstM), .d_srcA(d_srcA), .d_srcB(d_srcB),
        .F_predPC(F_predPC), .D_stat(D_stat), .D_icode(D_icode), .D_ifun(D_ifun),
        .D_rA(D_rA), .D_rB(D_rB), .D_valC(D_valC), .D_valP(D_valP),
        .E_stat(E_stat), .E_icode(E_icode), .E_ifun(E_ifun), .E_dstE(E_dstE),
        .E_dstM(E_dstM), .E_srcA(E_srcA), .E_srcB(E_srcB),
        .E_valC(E_valC), .E_valA(E_valA), .E_valB(E_valB),
        .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt), .ctrl_err(ctrl_err)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int sat_inc(input int v);
        return (v >= CNT_MAX) ? CNT_MAX : v + 1;
    endfunction

    task automatic model_reset();
        m_F = RESET_PC; m_D = D_NOP; m_E = E_NOP;
        m_stall = 0; m_bubble = 0; m_err = 1'b0;
    endtask

    // One clock edge of the pipeline as described by the control rules
    task automatic model_edge();
        d_rec_t fetched;
        e_rec_t decoded;
        fetched = '{stat: f_stat, icode: f_icode, ifun: f_ifun, rA: f_rA, rB: f_rB,
                    valC: f_valC, valP: f_valP};
        decoded = '{stat: d_stat, icode: d_icode, ifun: d_ifun, dstE: d_dstE, dstM: d_dstM,
                    srcA: d_srcA, srcB: d_srcB, valC: d_valC, valA: d_valA, valB: d_valB};
        if (!F_stall) m_F = f_predPC;
        if (D_stall) m_err = m_err | D_bubble;
        else m_D = D_bubble ? D_NOP : fetched;
        m_E = E_bubble ? E_NOP : decoded;
        if (F_stall || D_stall) m_stall = sat_inc(m_stall);
        if (D_bubble || E_bubble) m_bubble = sat_inc(m_bubble);
    endtask

    task automatic check_all();
        d_rec_t got_d;
        e_rec_t got_e;
        got_d = '{stat: D_stat, icode: D_icode, ifun: D_ifun, rA: D_rA, rB: D_rB,
                  valC: D_valC, valP: D_valP};
        got_e = '{stat: E_stat, icode: E_icode, ifun: E_ifun, dstE: E_dstE, dstM: E_dstM,
                  srcA: E_srcA, srcB: E_srcB, valC: E_valC, valA: E_valA, valB: E_valB};
        chk("F_predPC", F_predPC, m_F);
        chk("D_hdr", {44'h0, got_d.stat, got_d.icode, got_d.ifun, got_d.rA, got_d.rB},
            {44'h0, m_D.stat, m_D.icode, m_D.ifun, m_D.rA, m_D.rB});
        chk("D_valC", got_d.valC, m_D.valC);
        chk("D_valP", got_d.valP, m_D.valP);
        chk("E_hdr", {36'h0, got_e.stat, got_e.icode, got_e.ifun, got_e.dstE, got_e.dstM,
                      got_e.srcA, got_e.srcB},
            {36'h0, m_E.stat, m_E.icode, m_E.ifun, m_E.dstE, m_E.dstM, m_E.srcA, m_E.srcB});
        chk("E_valC", got_e.valC, m_E.valC);
        chk("E_valA", got_e.valA, m_E.valA);
        chk("E_valB", got_e.valB, m_E.valB);
        chk("stall_cnt", 64'(stall_cnt), 64'(m_stall));
        chk("bubble_cnt", 64'(bubble_cnt), 64'(m_bubble));
        chk("ctrl_err", 64'(ctrl_err), 64'(m_err));
    endtask

    // Called at posedge+1: one edge, then compare
    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    // Called at posedge+1: assert reset between edges, check immediately, release before next edge
    task automatic do_reset();
        #2 reset_n = 1'b0;
        #1;
        model_reset();
        check_all();
        #3 reset_n = 1'b1;
    endtask

    task automatic set_ctrl(input logic fs, input logic ds, input logic db, input logic eb);
        F_stall = fs; D_stall = ds; D_bubble = db; E_bubble = eb;
    endtask

    task automatic rand_data();
        f_predPC = {$urandom, $urandom};
        f_stat = 4'($urandom); f_icode = 4'($urandom); f_ifun = 4'($urandom);
        f_rA = 4'($urandom); f_rB = 4'($urandom);
        f_valC = {$urandom, $urandom}; f_valP = {$urandom, $urandom};
        d_stat = 4'($urandom); d_icode = 4'($urandom); d_ifun = 4'($urandom);
        d_dstE = 4'($urandom); d_dstM = 4'($urandom);
        d_srcA = 4'($urandom); d_srcB = 4'($urandom);
        d_valC = {$urandom, $urandom}; d_valA = {$urandom, $urandom}; d_valB = {$urandom, $urandom};
    endtask

    initial begin
        reset_n = 1'b0;
        set_ctrl(0, 0, 0, 0);
        rand_data();
        model_reset();
        @(posedge clk);
        #1;
        check_all();
        reset_n = 1'b1;

        // Dirty the registers, then check asynchronous reset
        cyc();
        do_reset();
        chk("rst_F", F_predPC, RESET_PC);
        chk("rst_Dicode", 64'(D_icode), 64'h1);
        chk("rst_EdstE", 64'(E_dstE), 64'hF);
        f_predPC = 64'h10;
        cyc();
        chk("pc_after_rst", F_predPC, 64'h10);

        // Normal flow
        f_icode = 4'h3; f_rB = 4'h2; f_valC = 64'h1234;
        cyc();
        chk("norm_Dicode", 64'(D_icode), 64'h3);
        chk("norm_DvalC", D_valC, 64'h1234);
        d_icode = 4'h3; d_dstE = 4'h2;
        cyc();
        chk("norm_Eicode", 64'(E_icode), 64'h3);
        chk("norm_EdstE", 64'(E_dstE), 64'h2);

        // Load/use hazard for two cycles while fetch keeps changing
        do_reset();
        rand_data();
        cyc();
        set_ctrl(1, 1, 0, 1);
        repeat (2) begin
            rand_data();
            cyc();
        end
        chk("lu_Eicode", 64'(E_icode), 64'h1);
        chk("lu_stall", 64'(stall_cnt), 64'd2);
        chk("lu_bubble", 64'(bubble_cnt), 64'd2);

        // Mispredict
        set_ctrl(0, 0, 1, 1);
        rand_data();
        cyc();
        chk("mp_DvalP", D_valP, 64'h0);
        chk("mp_bubble", 64'(bubble_cnt), 64'd3);
        chk("mp_F", F_predPC, f_predPC);

        // ret in flight
        set_ctrl(1, 0, 1, 0);
        rand_data();
        cyc();

        // Conflict: D held, flag sticky
        set_ctrl(0, 1, 1, 0);
        rand_data();
        cyc();
        chk("cf_err", 64'(ctrl_err), 64'h1);
        set_ctrl(0, 0, 0, 0);
        repeat (3) begin
            rand_data();
            cyc();
        end
        chk("cf_sticky", 64'(ctrl_err), 64'h1);

        // Saturation, then reset mid-stall
        do_reset();
        set_ctrl(1, 0, 0, 0);
        repeat (20) begin
            rand_data();
            cyc();
        end
        chk("sat_stall", 64'(stall_cnt), 64'(CNT_MAX));
        do_reset();
        chk("sat_rst_cnt", 64'(stall_cnt), 64'h0);
        chk("sat_rst_F", F_predPC, RESET_PC);

        // Randomized traffic with occasional asynchronous resets
        for (int i = 0; i < 400; i++) begin
            set_ctrl(($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                     ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
            rand_data();
            if ($urandom_range(0, 59) == 0) do_reset();
            else cyc();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
